// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the single-cycle core.
// Owns the architectural PC and picks the next PC from, in priority order:
//   return (RAS top, or RegTarget when the RAS is empty),
//   register-indirect branch, PC-relative unconditional branch,
//   taken conditional branch (CBZ/CBNZ), or the sequential PC.
// A circular return-address stack is pushed by BL and popped by RET.
//
// Ports:
//   CLK, resetl       clock / asynchronous active-low reset
//   stall             hold PC and RAS this cycle
//   SignExtImm        sign-extended branch offset, unshifted
//   Branch, BranchNZ  conditional branch and its polarity (1 = CBNZ)
//   ALUZero           ALU zero flag
//   Uncondbranch      PC-relative unconditional branch (B/BL)
//   Link              with Uncondbranch: push return address (BL)
//   BranchReg         register-indirect branch (BR)
//   Ret               return: pop RAS
//   RegTarget         BR target, and RET target when the RAS is empty
//   CurrentPC         registered PC
//   NextPC            combinational next PC
//   ras_count         number of valid RAS entries
//   ras_overflow      sticky: a push discarded the oldest entry
//   ras_underflow     combinational: Ret with an empty RAS this cycle
module pc_sequencer #(
  parameter int               WIDTH       = 64,
  parameter int               IMM_SHIFT   = 2,
  parameter int               INSTR_BYTES = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               RAS_DEPTH   = 4,
  localparam int              CW          = $clog2(RAS_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             stall,
  input  logic [WIDTH-1:0] SignExtImm,
  input  logic             Branch,
  input  logic             BranchNZ,
  input  logic             ALUZero,
  input  logic             Uncondbranch,
  input  logic             Link,
  input  logic             BranchReg,
  input  logic             Ret,
  input  logic [WIDTH-1:0] RegTarget,
  output logic [WIDTH-1:0] CurrentPC,
  output logic [WIDTH-1:0] NextPC,
  output logic [CW-1:0]    ras_count,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] rel_pc;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    top_ptr_inc;
  logic [PW-1:0]    top_ptr_dec;
  logic             ras_empty;
  logic             ras_full;
  logic             push;
  logic             pop;

  // Shift happens in WIDTH bits, so bits shifted past the MSB are dropped.
  assign offset = SignExtImm << IMM_SHIFT;
  assign seq_pc = CurrentPC + WIDTH'(INSTR_BYTES);
  assign rel_pc = CurrentPC + offset;

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_top   = ras_mem[top_ptr];

  // Pointer arithmetic modulo RAS_DEPTH, which need not be a power of two.
  assign top_ptr_inc = (top_ptr == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr + 1'b1;
  assign top_ptr_dec = (top_ptr == '0) ? PW'(RAS_DEPTH - 1) : top_ptr - 1'b1;

  // NOTE: every output of this block gets a default before the priority
  // chain, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    NextPC        = seq_pc;
    ras_underflow = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    if (Ret) begin
      if (!ras_empty) begin
        NextPC = ras_top;
        pop    = 1'b1;
      end else begin
        NextPC        = RegTarget;
        ras_underflow = 1'b1;
      end
    end else if (BranchReg) begin
      NextPC = RegTarget;
    end else if (Uncondbranch) begin
      NextPC = rel_pc;
      push   = Link;
    end else if (Branch && (ALUZero ^ BranchNZ)) begin
      NextPC = rel_pc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      CurrentPC    <= RESET_PC;
      ras_count    <= '0;
      ras_overflow <= 1'b0;
      top_ptr      <= '0;
    end else if (!stall) begin
      CurrentPC <= NextPC;
      if (pop) begin
        top_ptr   <= top_ptr_dec;
        ras_count <= ras_count - 1'b1;
      end else if (push) begin
        // When full, top_ptr_inc lands on the oldest entry, which the
        // write below overwrites; the count stays at RAS_DEPTH.
        top_ptr <= top_ptr_inc;
        if (ras_full) ras_overflow <= 1'b1;
        else          ras_count    <= ras_count + 1'b1;
      end
    end
  end

  // NOTE: the stack storage has no reset; ras_count marks which entries are
  // valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (!stall && push) ras_mem[top_ptr_inc] <= seq_pc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// BL/RET, overflow, stall and priority sequences, then randomized stimulus
// compared against a queue-based reference model.
module tb_pc_sequencer;

  localparam int          W        = 64;
  localparam logic [63:0] RST_PC   = 64'h1000;
  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          resetl = 1'b1;
  logic          stall, Branch, BranchNZ, ALUZero, Uncondbranch, Link, BranchReg, Ret;
  logic [W-1:0]  SignExtImm, RegTarget;
  logic [W-1:0]  CurrentPC, NextPC;
  logic [CW-1:0] ras_count;
  logic          ras_overflow, ras_underflow;

  pc_sequencer #(
    .WIDTH(W), .IMM_SHIFT(2), .INSTR_BYTES(4), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .resetl(resetl), .stall(stall), .SignExtImm(SignExtImm),
    .Branch(Branch), .BranchNZ(BranchNZ), .ALUZero(ALUZero),
    .Uncondbranch(Uncondbranch), .Link(Link), .BranchReg(BranchReg), .Ret(Ret),
    .RegTarget(RegTarget), .CurrentPC(CurrentPC), .NextPC(NextPC),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: PC value, return addresses as a queue (back = top).
  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  bit          m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_next();
    logic [63:0] off;
    off = SignExtImm * 64'd4;
    if (Ret)          return (m_ras.size() > 0) ? m_ras[$] : RegTarget;
    if (BranchReg)    return RegTarget;
    if (Uncondbranch) return m_pc + off;
    if (Branch && (ALUZero != BranchNZ)) return m_pc + off;
    return m_pc + 64'd4;
  endfunction

  task automatic idle();
    stall = 0; Branch = 0; BranchNZ = 0; ALUZero = 0; Uncondbranch = 0;
    Link = 0; BranchReg = 0; Ret = 0; SignExtImm = '0; RegTarget = '0;
  endtask

  // Check combinational outputs, advance the model, clock once, check state.
  task automatic tick();
    logic [63:0] nx;
    bit          uf;
    #1;
    nx = m_next();
    uf = Ret && (m_ras.size() == 0);
    check("next_pc", NextPC, nx);
    check("ras_underflow", 64'(ras_underflow), 64'(uf));
    if (!stall) begin
      if (Ret && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end else if (!Ret && !BranchReg && Uncondbranch && Link) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(m_pc + 64'd4);
      end
      m_pc = nx;
    end
    @(posedge CLK);
    #1;
    check("current_pc", CurrentPC, m_pc);
    check("ras_count", 64'(ras_count), 64'(m_ras.size()));
    check("ras_overflow", 64'(ras_overflow), 64'(m_ovf));
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    resetl = 1'b0;
    m_pc = RST_PC;
    m_ras.delete();
    m_ovf = 0;
    #1;
    check("reset_pc", CurrentPC, RST_PC);
    check("reset_ras_count", 64'(ras_count), 64'd0);
    check("reset_overflow", 64'(ras_overflow), 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
  endtask

  task automatic load_pc(input logic [63:0] pc);
    idle();
    BranchReg = 1; RegTarget = pc;
    tick();
    idle();
  endtask

  typedef struct {
    string       name;
    logic [63:0] start_pc;
    logic [63:0] imm;
    logic        branch, bnz, aluz, unc, breg;
    logic [63:0] regt;
    logic [63:0] exp_next;
  } vec_t;

  vec_t vecs[9];

  initial begin
    idle();
    #1;
    do_reset();

    // Reset then sequential fetch.
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_after_reset", CurrentPC, RST_PC + 64'(4 * i));
    end

    // Mid-cycle reset after the PC has moved.
    #3;
    do_reset();
    tick();
    check("seq_after_midreset", CurrentPC, 64'h1004);

    vecs[0] = '{"cbz_taken",      64'h2000, 64'd3, 1, 0, 1, 0, 0, 64'h0, 64'h200C};
    vecs[1] = '{"cbz_not_taken",  64'h2000, 64'd3, 1, 1, 1, 0, 0, 64'h0, 64'h2004};
    vecs[2] = '{"cbnz_taken",     64'h2000, 64'd3, 1, 1, 0, 0, 0, 64'h0, 64'h200C};
    vecs[3] = '{"cbz_nz_flag",    64'h2000, 64'd3, 1, 0, 0, 0, 0, 64'h0, 64'h2004};
    vecs[4] = '{"b_negative",     64'h4, -64'sd2, 0, 0, 0, 1, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[5] = '{"seq_wrap",       64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 0, 0, 0, 0, 64'h0, 64'h0};
    vecs[6] = '{"br_target",      64'h3000, 64'd5, 0, 0, 0, 0, 1, 64'h5550, 64'h5550};
    vecs[7] = '{"bnz_ignored",    64'h3000, 64'd5, 0, 1, 0, 0, 0, 64'h0, 64'h3004};
    vecs[8] = '{"shift_truncate", 64'h100, 64'h4000_0000_0000_0001, 0, 0, 0, 1, 0, 64'h0, 64'h104};

    foreach (vecs[i]) begin
      load_pc(vecs[i].start_pc);
      Branch = vecs[i].branch; BranchNZ = vecs[i].bnz; ALUZero = vecs[i].aluz;
      Uncondbranch = vecs[i].unc; BranchReg = vecs[i].breg;
      SignExtImm = vecs[i].imm; RegTarget = vecs[i].regt;
      #1;
      check({vecs[i].name, "_next"}, NextPC, vecs[i].exp_next);
      tick();
      check({vecs[i].name, "_pc"}, CurrentPC, vecs[i].exp_next);
    end

    // BL then RET then RET on empty stack.
    load_pc(64'h100);
    Uncondbranch = 1; Link = 1; SignExtImm = 64'h40;
    tick();
    check("bl_pc", CurrentPC, 64'h200);
    check("bl_count", 64'(ras_count), 64'd1);
    idle(); Ret = 1; RegTarget = 64'hABC0;
    tick();
    check("ret_pc", CurrentPC, 64'h104);
    check("ret_count", 64'(ras_count), 64'd0);
    #1;
    check("ret_empty_underflow", 64'(ras_underflow), 64'd1);
    tick();
    check("ret_empty_pc", CurrentPC, 64'hABC0);

    // Overflow: five BLs A..E, each target is the next call site.
    do_reset();
    load_pc(64'h1_0000);
    for (int i = 0; i < 5; i++) begin
      idle(); Uncondbranch = 1; Link = 1; SignExtImm = 64'h100;
      tick();
    end
    check("ovf_count", 64'(ras_count), 64'd4);
    check("ovf_flag", 64'(ras_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      idle(); Ret = 1; RegTarget = 64'h7770;
      tick();
      check("ovf_ret_pc", CurrentPC, 64'h1_1004 - 64'(i * 'h400));
    end
    #1;
    check("ovf_fifth_underflow", 64'(ras_underflow), 64'd1);
    tick();
    check("ovf_fifth_pc", CurrentPC, 64'h7770);
    check("ovf_sticky", 64'(ras_overflow), 64'd1);

    // Stall holds state but NextPC still shows the target.
    load_pc(64'h500);
    stall = 1; Uncondbranch = 1; Link = 1; SignExtImm = 64'h10;
    #1;
    check("stall_next", NextPC, 64'h540);
    tick();
    check("stall_pc", CurrentPC, 64'h500);
    check("stall_count", 64'(ras_count), 64'd0);

    // Ret beats BranchReg and Uncondbranch; no push happens.
    stall = 0;
    tick();
    check("prio_bl_count", 64'(ras_count), 64'd1);
    Ret = 1; BranchReg = 1; RegTarget = 64'h9990;
    tick();
    check("prio_ret_pc", CurrentPC, 64'h504);
    check("prio_ret_count", 64'(ras_count), 64'd0);
    tick();
    check("prio_empty_pc", CurrentPC, 64'h9990);
    check("prio_empty_count", 64'(ras_count), 64'd0);

    // Randomized stimulus against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] r;
      r = $urandom;
      stall        = ($urandom_range(0, 5) == 0);
      Ret          = ($urandom_range(0, 7) == 0);
      BranchReg    = ($urandom_range(0, 9) == 0);
      Uncondbranch = ($urandom_range(0, 4) == 0);
      Link         = $urandom_range(0, 1);
      Branch       = ($urandom_range(0, 3) == 0);
      BranchNZ     = $urandom_range(0, 1);
      ALUZero      = $urandom_range(0, 1);
      SignExtImm   = {{52{r[11]}}, r[11:0]};
      RegTarget    = {$urandom, $urandom} & ~64'h3;
      tick();
      if (n % 500 == 499) begin
        #3;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
